int_ack_sequencer: RTL and testbench

Interrupt acknowledge sequencer for the 8259-compatible PIC. It sits between the interrupt request register block, the in-service register and the CPU-side INTA pin. It resolves priority among pending unmasked requests, raises the CPU interrupt, and runs the two-pulse INTA protocol. It drives the request register's freeze and clear inputs, maintains the in-service register, and places the interrupt vector on the data bus.

---
 rtl/int_ack_sequencer.sv | 156 +++++++++++++++
 tb/tb_int_ack_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/int_ack_sequencer.sv
// Interrupt acknowledge sequencer for an 8259-compatible PIC: priority resolution,
// INT generation, two-pulse INTA protocol, in-service register and vector drive.
module int_ack_sequencer (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       write_initial_command_word_1,
   input  logic [7:0] interrupt_request_register,
   input  logic [7:0] interrupt_mask,
   input  logic       interrupt_acknowledge_n,
   input  logic       end_of_interrupt,
   input  logic       auto_eoi_config,
   input  logic [4:0] interrupt_vector_base,
   output logic       interrupt_to_cpu,
   output logic       freeze,
   output logic [7:0] clear_interrupt_request,
   output logic [7:0] in_service_register,
   output logic [7:0] data_bus_out,
   output logic       data_bus_out_enable
);

   typedef enum logic [1:0] {S_IDLE, S_ACK1, S_GAP, S_ACK2} state_t;

   state_t     r_state;
   logic       r_inta_q;
   logic       r_inta_armed;
   logic [2:0] r_level;
   logic       r_spurious;
   logic       r_int;
   logic       r_freeze;
   logic [7:0] r_clear;
   logic [7:0] r_isr;
   logic [7:0] r_dbo;
   logic       r_dboe;

   logic [7:0] w_eligible;
   logic [2:0] w_win_idx;
   logic       w_win_any;
   logic [2:0] w_isr_idx;
   logic       w_isr_any;
   logic       w_win_valid;
   logic       w_fall;
   logic       w_rise;
   logic [7:0] w_eoi_mask;
   logic [7:0] w_ack_set;
   logic [7:0] w_auto_clr;
   logic [7:0] w_isr_next;

   assign w_eligible = interrupt_request_register & ~interrupt_mask;

   // Scan downward so the lowest set index is the last one written.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      w_win_idx = 3'd0;
      w_win_any = 1'b0;
      w_isr_idx = 3'd0;
      w_isr_any = 1'b0;
      for (int i = 7; i >= 0; i--) begin
         if (w_eligible[i]) begin
            w_win_idx = 3'(i);
            w_win_any = 1'b1;
         end
         if (r_isr[i]) begin
            w_isr_idx = 3'(i);
            w_isr_any = 1'b1;
         end
      end
   end

   assign w_win_valid = w_win_any && (!w_isr_any || (w_win_idx < w_isr_idx));

   // The armed flag blocks a fall when INTA is already low as reset releases.
   assign w_fall = r_inta_q & r_inta_armed & ~interrupt_acknowledge_n;
   assign w_rise = ~r_inta_q & interrupt_acknowledge_n;

   assign w_eoi_mask = end_of_interrupt ? (r_isr & (~r_isr + 8'd1)) : 8'h00;
   assign w_ack_set  = (r_state == S_IDLE && w_fall && w_win_valid) ?
                       (8'h01 << w_win_idx) : 8'h00;
   assign w_auto_clr = (r_state == S_ACK2 && w_rise && auto_eoi_config && !r_spurious) ?
                       (8'h01 << r_level) : 8'h00;
   assign w_isr_next = (r_isr & ~w_eoi_mask & ~w_auto_clr) | w_ack_set;

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_inta_q     <= 1'b1;
         r_inta_armed <= 1'b0;
         r_level      <= 3'd0;
         r_spurious   <= 1'b0;
         r_int        <= 1'b0;
         r_freeze     <= 1'b0;
         r_clear      <= 8'h00;
         r_isr        <= 8'h00;
         r_dbo        <= 8'h00;
         r_dboe       <= 1'b0;
      end else begin
         r_inta_q <= interrupt_acknowledge_n;
         if (interrupt_acknowledge_n)
            r_inta_armed <= 1'b1;
         if (write_initial_command_word_1) begin
            r_state    <= S_IDLE;
            r_level    <= 3'd0;
            r_spurious <= 1'b0;
            r_int      <= 1'b0;
            r_freeze   <= 1'b0;
            r_clear    <= 8'h00;
            r_isr      <= 8'h00;
            r_dbo      <= 8'h00;
            r_dboe     <= 1'b0;
         end else begin
            r_clear <= w_ack_set;
            r_isr   <= w_isr_next;
            case (r_state)
               S_IDLE: begin
                  if (w_fall) begin
                     r_level    <= w_win_valid ? w_win_idx : 3'd7;
                     r_spurious <= !w_win_valid;
                     r_freeze   <= 1'b1;
                     r_int      <= 1'b0;
                     r_state    <= S_ACK1;
                  end else begin
                     r_int <= w_win_valid;
                  end
               end
               S_ACK1: begin
                  if (w_rise)
                     r_state <= S_GAP;
               end
               S_GAP: begin
                  if (w_fall) begin
                     r_dbo   <= {interrupt_vector_base, r_level};
                     r_dboe  <= 1'b1;
                     r_state <= S_ACK2;
                  end
               end
               S_ACK2: begin
                  if (w_rise) begin
                     r_dboe   <= 1'b0;
                     r_freeze <= 1'b0;
                     r_state  <= S_IDLE;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign interrupt_to_cpu        = r_int;
   assign freeze                  = r_freeze;
   assign clear_interrupt_request = r_clear;
   assign in_service_register     = r_isr;
   assign data_bus_out            = r_dbo;
   assign data_bus_out_enable     = r_dboe;

endmodule

// File: tb/tb_int_ack_sequencer.sv
// Self-checking bench for int_ack_sequencer: directed protocol scenarios followed by
// randomized acknowledge sequences checked against a transaction-level model.
module tb_int_ack_sequencer;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       icw1 = 1'b0;
   logic [7:0] irr = 8'h00;
   logic [7:0] mask = 8'h00;
   logic       inta_n = 1'b1;
   logic       eoi = 1'b0;
   logic       auto = 1'b0;
   logic [4:0] base = 5'd0;

   logic       int_out;
   logic       freeze;
   logic [7:0] clear;
   logic [7:0] isr;
   logic [7:0] dbo;
   logic       dboe;

   int checks = 0;
   int errors = 0;

   logic [7:0] m_isr;
   logic [2:0] m_level;
   logic       m_spur;

   int_ack_sequencer dut (
      .clock                        (clock),
      .reset_n                      (reset_n),
      .write_initial_command_word_1 (icw1),
      .interrupt_request_register   (irr),
      .interrupt_mask               (mask),
      .interrupt_acknowledge_n      (inta_n),
      .end_of_interrupt             (eoi),
      .auto_eoi_config              (auto),
      .interrupt_vector_base        (base),
      .interrupt_to_cpu             (int_out),
      .freeze                       (freeze),
      .clear_interrupt_request      (clear),
      .in_service_register          (isr),
      .data_bus_out                 (dbo),
      .data_bus_out_enable          (dboe)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model helpers: index of lowest set bit, 8 when empty.
   function automatic int lowest(input logic [7:0] v);
      for (int i = 0; i < 8; i++)
         if (v[i]) return i;
      return 8;
   endfunction

   function automatic logic model_valid(input logic [7:0] r, input logic [7:0] m,
                                        input logic [7:0] s);
      int w;
      w = lowest(r & ~m);
      return (w < 8) && (w < lowest(s));
   endfunction

   function automatic logic [7:0] model_eoi(input logic [7:0] s);
      logic [7:0] t;
      int k;
      t = s;
      k = lowest(s);
      if (k < 8) t[k] = 1'b0;
      return t;
   endfunction

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic eoi_pulse;
      eoi = 1'b1;
      tick;
      eoi = 1'b0;
      m_isr = model_eoi(m_isr);
      check("eoi_isr", isr, m_isr);
   endtask

   // First INTA pulse: l1 low cycles, then the rising edge (ends in GAP).
   task automatic first_pulse(input int l1, input logic eoi_now, input logic [7:0] irr_after);
      logic [7:0] exp_clear;
      logic       v;
      int         w;
      v = model_valid(irr, mask, m_isr);
      w = lowest(irr & ~mask);
      m_spur = !v;
      m_level = v ? 3'(w) : 3'd7;
      exp_clear = v ? (8'h01 << w) : 8'h00;
      if (eoi_now) m_isr = model_eoi(m_isr);
      m_isr = m_isr | exp_clear;
      inta_n = 1'b0;
      eoi = eoi_now;
      tick;
      check("fall_freeze", freeze, 1);
      check("fall_int", int_out, 0);
      check("fall_clear", clear, exp_clear);
      check("fall_isr", isr, m_isr);
      eoi = 1'b0;
      irr = irr_after;
      for (int i = 1; i < l1; i++) begin
         tick;
         check("ack1_clear", clear, 0);
         check("ack1_freeze", freeze, 1);
      end
      inta_n = 1'b1;
      tick;
      check("rise1_clear", clear, 0);
      check("rise1_freeze", freeze, 1);
      check("rise1_int", int_out, 0);
   endtask

   task automatic gap(input int g);
      for (int i = 1; i < g; i++) begin
         tick;
         check("gap_enable", dboe, 0);
         check("gap_freeze", freeze, 1);
      end
   endtask

   task automatic second_pulse(input int l2);
      logic [7:0] exp_vec;
      exp_vec = {base, m_level};
      inta_n = 1'b0;
      for (int i = 0; i < l2; i++) begin
         tick;
         check("vec", dbo, exp_vec);
         check("vec_enable", dboe, 1);
         check("vec_freeze", freeze, 1);
         check("vec_isr", isr, m_isr);
      end
      if (auto && !m_spur) m_isr[m_level] = 1'b0;
      inta_n = 1'b1;
      tick;
      check("rise2_enable", dboe, 0);
      check("rise2_freeze", freeze, 0);
      check("rise2_isr", isr, m_isr);
   endtask

   initial begin
      m_isr = 8'h00;
      m_level = 3'd0;
      m_spur = 1'b0;
      reset_n = 1'b0;
      #12;
      check("rst_int", int_out, 0);
      check("rst_freeze", freeze, 0);
      check("rst_clear", clear, 0);
      check("rst_isr", isr, 0);
      check("rst_dbo", dbo, 0);
      check("rst_dboe", dboe, 0);
      reset_n = 1'b1;
      tick;
      tick;
      check("idle_int", int_out, 0);

      // Basic sequence: IRR 0x24, vector base 01000.
      base = 5'b01000;
      irr = 8'h24;
      tick;
      check("t1_int", int_out, 1);
      first_pulse(2, 1'b0, 8'h24);
      check("t1_isr", isr, 8'h04);
      gap(2);
      second_pulse(2);
      check("t1_level", {base, m_level}, 8'h42);
      irr = 8'h20;

      // Nesting: lower priority blocked by ISR bit 2, IR0 preempts.
      tick;
      check("nest_blocked", int_out, 0);
      irr = 8'h21;
      tick;
      check("nest_int", int_out, 1);
      first_pulse(1, 1'b0, 8'h21);
      check("nest_isr", isr, 8'h05);
      gap(1);
      second_pulse(1);
      irr = 8'h20;
      eoi_pulse();
      check("eoi_05", isr, 8'h04);

      // Spurious: request withdrawn before the first fall.
      irr = 8'h02;
      tick;
      check("spur_int", int_out, 1);
      irr = 8'h00;
      first_pulse(2, 1'b0, 8'h00);
      check("spur_isr", isr, 8'h04);
      gap(2);
      second_pulse(2);
      check("spur_level", m_level, 7);
      eoi_pulse();

      // Auto-EOI on IR7.
      auto = 1'b1;
      irr = 8'h80;
      tick;
      check("aeoi_int", int_out, 1);
      first_pulse(2, 1'b0, 8'h80);
      check("aeoi_isr_set", isr, 8'h80);
      gap(1);
      second_pulse(2);
      check("aeoi_isr_after", isr, 8'h00);
      auto = 1'b0;

      // EOI coinciding with the ISR set on the first fall.
      irr = 8'h10;
      tick;
      first_pulse(1, 1'b0, 8'h10);
      gap(1);
      second_pulse(1);
      irr = 8'h08;
      tick;
      first_pulse(1, 1'b1, 8'h08);
      check("eoi_coincide_isr", isr, 8'h08);
      gap(1);
      second_pulse(1);
      eoi_pulse();

      // Soft reset during GAP.
      irr = 8'h01;
      tick;
      first_pulse(2, 1'b0, 8'h01);
      icw1 = 1'b1;
      tick;
      icw1 = 1'b0;
      m_isr = 8'h00;
      check("srst_int", int_out, 0);
      check("srst_freeze", freeze, 0);
      check("srst_clear", clear, 0);
      check("srst_isr", isr, 0);
      check("srst_dbo", dbo, 0);
      check("srst_dboe", dboe, 0);
      tick;
      check("srst_idle_int", int_out, 1);
      first_pulse(1, 1'b0, 8'h01);
      check("srst_reack_isr", isr, 8'h01);
      gap(1);
      second_pulse(1);
      eoi_pulse();

      // Asynchronous reset during ACK2.
      irr = 8'h02;
      tick;
      first_pulse(1, 1'b0, 8'h02);
      gap(2);
      inta_n = 1'b0;
      tick;
      check("ack2_dboe", dboe, 1);
      #1 reset_n = 1'b0;
      #1;
      check("arst_dboe", dboe, 0);
      check("arst_freeze", freeze, 0);
      check("arst_isr", isr, 0);
      m_isr = 8'h00;

      // INTA already low at reset release: no fall until it returns high.
      irr = 8'h01;
      tick;
      reset_n = 1'b1;
      tick;
      tick;
      check("lowrel_freeze", freeze, 0);
      check("lowrel_int", int_out, 1);
      check("lowrel_isr", isr, 0);
      inta_n = 1'b1;
      tick;
      check("lowrel_high_freeze", freeze, 0);
      first_pulse(1, 1'b0, 8'h01);
      gap(1);
      second_pulse(1);
      eoi_pulse();

      // Randomized sequences against the model.
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 1) == 1) eoi_pulse();
         irr  = 8'($urandom);
         mask = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
         base = 5'($urandom);
         auto = 1'($urandom_range(0, 1));
         tick;
         check("rnd_int", int_out, model_valid(irr, mask, m_isr));
         first_pulse($urandom_range(1, 3), 1'($urandom_range(0, 1)), 8'($urandom));
         gap($urandom_range(1, 3));
         second_pulse($urandom_range(1, 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
